pairing_operand_loader: RTL and testbench

Upstream feeder for the Tate pairing core over GF(3^97). It collects the four 194-bit operands x1, y1, x2, y2 from a narrow valid/ready word stream and checks that every 2-bit trit encoding is legal. It then holds the operands stable, pulses the core's launch input, and blocks new input until the core reports completion. Malformed operand sets are discarded with an error flag and never reach the core.

---
 rtl/pairing_operand_loader_if.sv | 30 +++
 rtl/pairing_operand_loader.sv | 128 ++++++++++++
 tb/tb_pairing_operand_loader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pairing_operand_loader_if.sv
// Word stream and core-side bundle between the operand feeder, the loader and the
// GF(3^M) Tate pairing core.
interface pairing_operand_loader_if #(
  parameter int M = 97,
  parameter int W = 32
);
  // A word moves on a rising clk edge where in_valid and in_ready are both high.
  // The source holds in_data/in_valid until that edge. in_ready never looks at in_valid.
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [2*M-1:0] x1;
  logic [2*M-1:0] y1;
  logic [2*M-1:0] x2;
  logic [2*M-1:0] y2;
  logic           core_start;
  logic           core_done;
  logic           busy;
  logic           err;

  modport master (
    output in_data, in_valid, core_done,
    input  in_ready, x1, y1, x2, y2, core_start, busy, err
  );

  modport slave (
    input  in_data, in_valid, core_done,
    output in_ready, x1, y1, x2, y2, core_start, busy, err
  );
endinterface

// File: rtl/pairing_operand_loader.sv
// Collects x1, y1, x2, y2 as a trit-checked word stream, launches the pairing core
// once per clean set, and blocks input until the core signals completion.
module pairing_operand_loader #(
  parameter int  M = 97,
  parameter int  W = 32,
  localparam int NW = (2 * M + W - 1) / W,
  localparam int WCW = $clog2(4 * NW)
) (
  input  logic                     clk,
  input  logic                     reset,
  pairing_operand_loader_if.slave  bus,
  output logic [1:0]               dbg_state,
  output logic [WCW-1:0]           dbg_wc
);

  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
  localparam int LAST_BITS = 2 * M - (NW - 1) * W;
  localparam logic [W-1:0] PAD_MASK = {W{1'b1}} << LAST_BITS;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [WIW-1:0] word_idx;
  logic [1:0]     op_idx;
  logic           bad_q;
  logic           err_q;
  logic           core_done_q;
  logic [2*M-1:0] ops_q [4];

  logic accept, first_word, last_word, final_word;
  logic trit_bad, pad_bad, word_bad, set_bad;

  assign accept     = bus.in_valid && (state_q == LOAD);
  assign first_word = (word_idx == '0) && (op_idx == 2'd0);
  assign last_word  = (word_idx == WIW'(NW - 1));
  assign final_word = last_word && (op_idx == 2'd3);

  always_comb begin
    trit_bad = 1'b0;
    for (int i = 0; i < W / 2; i++) begin
      trit_bad = trit_bad | (bus.in_data[2*i] & bus.in_data[2*i+1]);
    end
  end

  assign pad_bad  = last_word && (|(bus.in_data & PAD_MASK));
  assign word_bad = trit_bad || pad_bad;
  // The final word's own check must count, since bad_q only sees it one edge later.
  assign set_bad  = bad_q || word_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && final_word && !set_bad) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (bus.core_done && !core_done_q) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx    <= '0;
      op_idx      <= 2'd0;
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
      core_done_q <= 1'b0;
    end else begin
      core_done_q <= bus.core_done;
      if (accept) begin
        if (last_word) begin
          word_idx <= '0;
          op_idx   <= op_idx + 2'd1;
        end else begin
          word_idx <= word_idx + WIW'(1);
        end
        bad_q <= first_word ? word_bad : set_bad;
        if (final_word && set_bad) begin
          err_q <= 1'b1;
        end else if (first_word) begin
          err_q <= 1'b0;
        end
      end
    end
  end

  // Padding above bit 2*M of each operand's last word is checked but never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < 4; o++) begin
        ops_q[o] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < NW - 1; k++) begin
        if (word_idx == WIW'(k)) begin
          ops_q[op_idx][k*W +: W] <= bus.in_data;
        end
      end
      if (last_word) begin
        ops_q[op_idx][(NW-1)*W +: LAST_BITS] <= bus.in_data[LAST_BITS-1:0];
      end
    end
  end

  assign bus.in_ready   = (state_q == LOAD);
  assign bus.core_start = (state_q == START);
  assign bus.busy       = (state_q == START) || (state_q == WAIT);
  assign bus.err        = err_q;
  assign bus.x1         = ops_q[0];
  assign bus.y1         = ops_q[1];
  assign bus.x2         = ops_q[2];
  assign bus.y2         = ops_q[3];

  assign dbg_state = state_q;
  assign dbg_wc    = WCW'(op_idx) * WCW'(NW) + WCW'(word_idx);

endmodule

// File: tb/tb_pairing_operand_loader.sv
// Directed bench for pairing_operand_loader: clean, malformed, backpressured,
// stale-done and mid-load-reset operand sets with hand-computed operands.
module tb_pairing_operand_loader;
  localparam int M  = 97;
  localparam int W  = 32;
  localparam int OW = 2 * M;
  localparam logic [OW-1:0] ONES = {97{2'b01}};

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  logic [4:0] dbg_wc;

  pairing_operand_loader_if #(.M(M), .W(W)) bus ();

  pairing_operand_loader dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_wc    (dbg_wc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  bit stale_mode = 1'b0;
  logic [4*OW-1:0] exp_q[$];
  logic [W-1:0] words [28];

  task automatic check(input string tag, input logic [4*OW-1:0] obs, input logic [4*OW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every launch must carry the next expected operand set; the core model drops done on launch.
  always @(negedge clk) begin
    if (bus.core_start === 1'b1) begin
      n_starts++;
      if (exp_q.size() == 0) check("unexpected_start", bus.core_start, 0);
      else check("launch_operands", {bus.x1, bus.y1, bus.x2, bus.y2}, exp_q.pop_front());
      if (!stale_mode) bus.core_done = 1'b0;
    end
  end

  // driver tasks
  task automatic load_clean();
    for (int k = 0; k < 28; k++) words[k] = '0;
    words[0] = 32'h0000_0001;
    words[7] = 32'h0000_0002;
    for (int k = 14; k < 28; k++) words[k] = (k % 7 == 6) ? 32'h0000_0001 : 32'h5555_5555;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("ready_timeout", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit gaps);
    for (int k = lo; k <= hi; k++) send_word(words[k], gaps);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.core_start !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("start_timeout", bus.core_start, 1);
  endtask

  // Called #1 after an edge with the loader in WAIT.
  task automatic finish_core();
    bus.core_done = 1'b1;
    @(negedge clk);
    check("busy_until_done_seen", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("done_busy_low", bus.busy, 0);
    check("done_ready_high", bus.in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.core_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_core_start", bus.core_start, 0);
    check("rst_err", bus.err, 0);
    check("rst_wc", dbg_wc, 0);
    check("rst_state", dbg_state, 0);
    check("rst_ops", {bus.x1, bus.y1, bus.x2, bus.y2}, 0);
    @(posedge clk); #1;

    // clean set, no gaps
    load_clean();
    exp_q.push_back({OW'(1), OW'(2), ONES, ONES});
    send_range(0, 27, 1'b0);
    @(negedge clk);
    check("clean_start_pulse", bus.core_start, 1);
    check("clean_busy", bus.busy, 1);
    check("clean_ready_low", bus.in_ready, 0);
    check("clean_x1", bus.x1, 1);
    check("clean_y1", bus.y1, 2);
    check("clean_x2", bus.x2, ONES);
    check("clean_y2", bus.y2, ONES);
    check("clean_err", bus.err, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("clean_start_one_cycle", bus.core_start, 0);
    check("clean_wait_busy", bus.busy, 1);
    check("clean_wait_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    finish_core();
    check("clean_start_count", n_starts, 1);

    // illegal trit in y1 word 3
    load_clean();
    words[10] = 32'h0000_0003;
    send_range(0, 27, 1'b0);
    @(negedge clk);
    check("trit_err", bus.err, 1);
    check("trit_no_start", bus.core_start, 0);
    check("trit_ready", bus.in_ready, 1);
    check("trit_wc", dbg_wc, 0);
    @(posedge clk); #1;

    // next clean set clears err on its first word
    load_clean();
    exp_q.push_back({OW'(1), OW'(2), ONES, ONES});
    send_word(words[0], 1'b0);
    @(negedge clk);
    check("err_clear_first_word", bus.err, 0);
    @(posedge clk); #1;
    send_range(1, 27, 1'b0);
    @(negedge clk);
    check("recover_start", bus.core_start, 1);
    @(posedge clk); #1;
    finish_core();

    // nonzero padding in x2 word 6
    load_clean();
    words[20] = 32'h0000_0005;
    send_range(0, 27, 1'b0);
    @(negedge clk);
    check("pad_err", bus.err, 1);
    check("pad_no_start", bus.core_start, 0);
    check("pad_ready", bus.in_ready, 1);
    repeat (3) @(negedge clk);
    check("pad_err_sticky", bus.err, 1);
    @(posedge clk); #1;

    // random gaps; the second set is offered while the first is in the core
    load_clean();
    exp_q.push_back({OW'(1), OW'(2), ONES, ONES});
    exp_q.push_back({OW'(1) | (OW'(6) << 32), OW'(2), ONES, ONES});
    fork
      begin
        send_range(0, 27, 1'b1);
        words[1] = 32'h0000_0006;
        send_range(0, 27, 1'b1);
      end
      begin
        repeat (2) begin
          wait_start();
          repeat (20) @(posedge clk);
          #1 bus.core_done = 1'b1;
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_busy", bus.busy, 0);
    check("bp_idle_wc", dbg_wc, 0);
    check("bp_start_count", n_starts, 4);
    @(posedge clk); #1;

    // stale done: held high across launch, dropped at start+2, raised at start+50
    stale_mode = 1'b1;
    load_clean();
    exp_q.push_back({OW'(1), OW'(2), ONES, ONES});
    send_range(0, 27, 1'b0);
    @(negedge clk);
    check("stale_start", bus.core_start, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.core_done = 1'b0;
    repeat (47) @(posedge clk);
    #1;
    @(negedge clk);
    check("stale_busy_hold", bus.busy, 1);
    @(posedge clk); #1;
    bus.core_done = 1'b1;
    @(negedge clk);
    check("stale_busy_at_rise", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("stale_busy_release", bus.busy, 0);
    check("stale_ready", bus.in_ready, 1);
    stale_mode = 1'b0;
    @(posedge clk); #1;

    // reset after word 13, then a full set
    load_clean();
    send_range(0, 13, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ops", {bus.x1, bus.y1, bus.x2, bus.y2}, 0);
    check("midrst_wc", dbg_wc, 0);
    check("midrst_ready", bus.in_ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_err", bus.err, 0);
    check("midrst_start", bus.core_start, 0);
    @(posedge clk); #1;
    exp_q.push_back({OW'(1), OW'(2), ONES, ONES});
    send_range(0, 27, 1'b0);
    @(negedge clk);
    check("postrst_start", bus.core_start, 1);
    @(posedge clk); #1;
    finish_core();

    // final report
    check("exp_q_drained", exp_q.size(), 0);
    check("total_starts", n_starts, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
